div_seq: RTL and testbench
==========================

DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 div_seq SHALL have no parameters: data width is fixed at 32 bits and command width at 1 bit.
REQ-002 Ports, in order:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- div_req_i  in  1  start request; sampled only in IDLE.
- div_op1_i  in  32  dividend.
- div_op2_i  in  32  divisor.
- div_signed_i  in  1  1 = DIV/REM, 0 = DIVU/REMU.
- div_rem_i  in  1  1 = return remainder, 0 = return quotient.
- div_busy_o  out  1  high in every state except IDLE.
- div_rdy_o  out  1  one-cycle result-valid pulse.
- div_res_o  out  32  result; valid only while div_rdy_o is high.
- div2adder_op1_o  out  32  1st operand to the main adder.
- div2adder_op2_o  out  32  2nd operand to the main adder.
- div2adder_cmd_o  out  1  adder command: 1 = add, 0 = subtract; always driven 0.
- adder2div_res_i  in  32  adder difference.
- adder2div_flags_i  in  4  adder flags in {c,z,s,o} order; bit 3 is carry/borrow.

Function
REQ-003 States SHALL be IDLE, CALC, CORR and DONE.
REQ-004 In IDLE with div_req_i=1, the block SHALL latch the operands, the signedness and the quotient/remainder select.
REQ-005 In the same accept cycle it SHALL store operand magnitudes: two's-complement absolute value when div_signed_i=1, unchanged otherwise.
REQ-006 Accept SHALL go to DONE if the divisor is 0 or the operation is signed 0x80000000/0xFFFFFFFF, and to CALC otherwise.
REQ-007 CALC SHALL run exactly 32 cycles, one quotient bit per cycle, MSB first, using a 6-bit iteration counter.
REQ-008 Each CALC cycle SHALL drive op1 = {partial_rem[30:0], next dividend bit}, op2 = divisor magnitude, cmd = 0.
REQ-009 A CALC step SHALL succeed when adder borrow flag bit 3 = 0 or partial_rem[31] = 1 (33-bit shifted value).
- On success: partial_rem <= adder2div_res_i and quotient bit = 1.
- Otherwise: partial_rem <= shifted op1 and quotient bit = 0.
REQ-010 After the 32nd CALC cycle the block SHALL enter CORR.
REQ-011 CORR SHALL negate the quotient when signed and operand signs differ, and negate the remainder when signed and the dividend is negative; then it SHALL go to DONE.
REQ-012 DONE SHALL assert div_rdy_o for exactly one cycle with the selected result and then return to IDLE.
REQ-013 Latency SHALL be 34 clock edges from accept to entering DONE for normal operations and 1 edge for special cases.
REQ-014 Divide by zero SHALL return quotient 0xFFFFFFFF and remainder equal to the dividend, for both signed and unsigned operations.
REQ-015 Signed overflow (0x80000000/0xFFFFFFFF) SHALL return quotient 0x80000000 and remainder 0.
REQ-016 Outside CALC the adder outputs SHALL be driven to all-zero operands with cmd = 0.
REQ-017 div_req_i SHALL be ignored while div_busy_o=1, and operand changes after accept SHALL have no effect.
REQ-018 A new request may be accepted in the cycle immediately after DONE.

Reset
REQ-019 Asserting rst SHALL immediately force state IDLE, counter 0, div_busy_o=0, div_rdy_o=0 and div_res_o=0, in any state including mid-CALC.
REQ-020 On deassertion of rst the block SHALL accept a new request on the first clock edge, with no partial result emitted.

Configuration
REQ-021 With SCR1_DIV_KILL_EN defined, the block SHALL add an input port div_kill_i (1 bit), placed after div_rem_i.
REQ-022 With SCR1_DIV_KILL_EN defined, div_kill_i=1 in CALC or CORR SHALL return the block to IDLE on the next edge with no div_rdy_o pulse.
REQ-023 With SCR1_DIV_KILL_EN defined, div_kill_i SHALL have priority over div_req_i in IDLE, so a kill in the accept cycle drops the request.
REQ-024 Without SCR1_DIV_KILL_EN, the block SHALL have no div_kill_i port and every accepted operation SHALL run to DONE.

Structure
REQ-025 The state enum, data width constant (32) and flag-bit index constants SHALL live in the shared package scr1_ialu_pkg, and the adder flag struct SHALL move there too.
REQ-026 div_seq SHALL contain no sub-module; the main adder SHALL be instantiated beside it by the parent and connected through the div2adder/adder2div ports.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- DIVU 100/7 -> div_rdy_o 34 edges after accept; result 14, and 2 with div_rem_i=1.
- DIV -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- DIVU 0xFFFFFFFF/1 -> quotient 0xFFFFFFFF, remainder 0 (exercises the 33-bit success path).
- DIVU 5/0 -> quotient 0xFFFFFFFF, remainder 5, rdy 1 edge after accept.
- DIV 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0, rdy 1 edge after accept.
- rst asserted at CALC cycle 10 -> outputs zero immediately; a following 9/3 request returns 3.
- With SCR1_DIV_KILL_EN, kill at CALC cycle 5 -> no rdy pulse and busy low next cycle.

Source files
------------

// File: rtl/scr1_ialu_pkg.sv
// Shared integer-ALU definitions: divider state encoding, data width,
// main-adder flag layout and a small magnitude helper.
package scr1_ialu_pkg;

    localparam int unsigned DIV_WIDTH = 32;

    // Adder flag vector is {c, z, s, o}; carry/borrow sits in the top bit.
    localparam int unsigned FLAG_C_IDX = 3;
    localparam int unsigned FLAG_Z_IDX = 2;
    localparam int unsigned FLAG_S_IDX = 1;
    localparam int unsigned FLAG_O_IDX = 0;

    localparam logic [DIV_WIDTH-1:0] DIV_INT_MIN = {1'b1, {(DIV_WIDTH-1){1'b0}}};

    typedef struct packed {
        logic c;
        logic z;
        logic s;
        logic o;
    } adder_flags_t;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_CORR = 2'd2,
        DIV_DONE = 2'd3
    } div_state_t;

    // Two's-complement absolute value for signed operands, pass-through otherwise.
    function automatic logic [DIV_WIDTH-1:0] div_mag(input logic [DIV_WIDTH-1:0] v,
                                                     input logic is_signed);
        return (is_signed && v[DIV_WIDTH-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/div_seq.sv
// Sequential restoring divider (DIV/DIVU/REM/REMU), one quotient bit per
// cycle, sharing the main adder through the div2adder/adder2div ports.
// Optional feature: define SCR1_DIV_KILL_EN to add the div_kill_i abort input.
//
//  state | meaning
//  IDLE  | waiting for div_req_i; operands latched on accept
//  CALC  | 32 shift/subtract steps, MSB first
//  CORR  | sign fix-up of quotient and remainder
//  DONE  | one-cycle div_rdy_o with the selected result
module div_seq
    import scr1_ialu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 div_req_i,
    input  logic [DIV_WIDTH-1:0] div_op1_i,
    input  logic [DIV_WIDTH-1:0] div_op2_i,
    input  logic                 div_signed_i,
    input  logic                 div_rem_i,
`ifdef SCR1_DIV_KILL_EN
    input  logic                 div_kill_i,
`endif
    output logic                 div_busy_o,
    output logic                 div_rdy_o,
    output logic [DIV_WIDTH-1:0] div_res_o,
    output logic [DIV_WIDTH-1:0] div2adder_op1_o,
    output logic [DIV_WIDTH-1:0] div2adder_op2_o,
    output logic                 div2adder_cmd_o,
    input  logic [DIV_WIDTH-1:0] adder2div_res_i,
    input  logic [3:0]           adder2div_flags_i
);

    localparam logic [5:0] ITER_LAST = 6'(DIV_WIDTH - 1);

    div_state_t           state;
    div_state_t           state_next;
    logic [5:0]           iter_cnt;
    logic [DIV_WIDTH-1:0] part_rem;
    logic [DIV_WIDTH-1:0] quo;
    logic [DIV_WIDTH-1:0] dvsr_mag;
    logic                 rem_sel;
    logic                 quo_neg;
    logic                 rem_neg;

    logic                 kill;
    logic                 accept;
    logic                 op2_zero;
    logic                 sgn_ovf;
    logic                 borrow;
    logic                 step_ok;
    logic [DIV_WIDTH-1:0] shifted;
    logic                 unused_flags;

`ifdef SCR1_DIV_KILL_EN
    assign kill = div_kill_i;
`else
    assign kill = 1'b0;
`endif

    assign accept   = (state == DIV_IDLE) && div_req_i && !kill;
    assign op2_zero = (div_op2_i == '0);
    assign sgn_ovf  = div_signed_i && (div_op1_i == DIV_INT_MIN) && (div_op2_i == '1);

    // Only the borrow flag matters for a compare-by-subtract step.
    assign borrow       = adder2div_flags_i[FLAG_C_IDX];
    assign unused_flags = ^{adder2div_flags_i[FLAG_Z_IDX],
                            adder2div_flags_i[FLAG_S_IDX],
                            adder2div_flags_i[FLAG_O_IDX]};

    // Shifted partial remainder is 33 bits wide; its top bit alone forces success.
    assign shifted = {part_rem[DIV_WIDTH-2:0], quo[DIV_WIDTH-1]};
    assign step_ok = !borrow || part_rem[DIV_WIDTH-1];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= DIV_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            DIV_IDLE: begin
                if (accept) begin
                    state_next = (op2_zero || sgn_ovf) ? DIV_DONE : DIV_CALC;
                end
            end
            DIV_CALC: begin
                if (kill) begin
                    state_next = DIV_IDLE;
                end else if (iter_cnt == '0) begin
                    state_next = DIV_CORR;
                end
            end
            DIV_CORR: state_next = kill ? DIV_IDLE : DIV_DONE;
            DIV_DONE: state_next = DIV_IDLE;
            default:  state_next = DIV_IDLE;
        endcase
    end

    // Operand capture, iteration datapath and sign correction.
    // quo starts as the dividend magnitude and is shifted left each step, so its
    // MSB feeds the next dividend bit while quotient bits fill in from the LSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iter_cnt <= '0;
            part_rem <= '0;
            quo      <= '0;
            dvsr_mag <= '0;
            rem_sel  <= 1'b0;
            quo_neg  <= 1'b0;
            rem_neg  <= 1'b0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (accept) begin
                        rem_sel  <= div_rem_i;
                        quo_neg  <= div_signed_i && (div_op1_i[DIV_WIDTH-1] ^ div_op2_i[DIV_WIDTH-1]);
                        rem_neg  <= div_signed_i && div_op1_i[DIV_WIDTH-1];
                        dvsr_mag <= div_mag(div_op2_i, div_signed_i);
                        iter_cnt <= ITER_LAST;
                        if (op2_zero) begin
                            quo      <= '1;
                            part_rem <= div_op1_i;
                        end else if (sgn_ovf) begin
                            quo      <= DIV_INT_MIN;
                            part_rem <= '0;
                        end else begin
                            quo      <= div_mag(div_op1_i, div_signed_i);
                            part_rem <= '0;
                        end
                    end
                end
                DIV_CALC: begin
                    part_rem <= step_ok ? adder2div_res_i : shifted;
                    quo      <= {quo[DIV_WIDTH-2:0], step_ok};
                    iter_cnt <= iter_cnt - 6'd1;
                end
                DIV_CORR: begin
                    if (quo_neg) begin
                        quo <= -quo;
                    end
                    if (rem_neg) begin
                        part_rem <= -part_rem;
                    end
                end
                default: ;
            endcase
        end
    end

    // Adder is only borrowed during CALC; otherwise present a quiet zero subtract.
    always_comb begin
        div2adder_op1_o = '0;
        div2adder_op2_o = '0;
        div2adder_cmd_o = 1'b0;
        if (state == DIV_CALC) begin
            div2adder_op1_o = shifted;
            div2adder_op2_o = dvsr_mag;
        end
    end

    assign div_busy_o = (state != DIV_IDLE);
    assign div_rdy_o  = (state == DIV_DONE);
    assign div_res_o  = div_rdy_o ? (rem_sel ? part_rem : quo) : '0;

endmodule

// File: tb/tb_div_seq.sv
// Directed + random bench for div_seq with a behavioural main adder and a
// scoreboard of expected results/latencies.
module tb_div_seq;
    import scr1_ialu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        div_req_i;
    logic [31:0] div_op1_i;
    logic [31:0] div_op2_i;
    logic        div_signed_i;
    logic        div_rem_i;
`ifdef SCR1_DIV_KILL_EN
    logic        div_kill_i;
`endif
    logic        div_busy_o;
    logic        div_rdy_o;
    logic [31:0] div_res_o;
    logic [31:0] div2adder_op1_o;
    logic [31:0] div2adder_op2_o;
    logic        div2adder_cmd_o;
    logic [31:0] adder2div_res_i;
    logic [3:0]  adder2div_flags_i;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    div_seq dut (
        .clk               (clk),
        .rst               (rst),
        .div_req_i         (div_req_i),
        .div_op1_i         (div_op1_i),
        .div_op2_i         (div_op2_i),
        .div_signed_i      (div_signed_i),
        .div_rem_i         (div_rem_i),
`ifdef SCR1_DIV_KILL_EN
        .div_kill_i        (div_kill_i),
`endif
        .div_busy_o        (div_busy_o),
        .div_rdy_o         (div_rdy_o),
        .div_res_o         (div_res_o),
        .div2adder_op1_o   (div2adder_op1_o),
        .div2adder_op2_o   (div2adder_op2_o),
        .div2adder_cmd_o   (div2adder_cmd_o),
        .adder2div_res_i   (adder2div_res_i),
        .adder2div_flags_i (adder2div_flags_i)
    );

    // Behavioural main adder (subtract only, since the divider never adds).
    adder_flags_t add_flags;
    logic [32:0]  add_wide;
    always_comb begin
        add_wide    = {1'b0, div2adder_op1_o} - {1'b0, div2adder_op2_o};
        add_flags.c = add_wide[32];
        add_flags.z = (add_wide[31:0] == 32'd0);
        add_flags.s = add_wide[31];
        add_flags.o = (div2adder_op1_o[31] != div2adder_op2_o[31]) &&
                      (add_wide[31] != div2adder_op1_o[31]);
    end
    assign adder2div_res_i   = add_wide[31:0];
    assign adder2div_flags_i = add_flags;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic is_special(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        return (b == 32'd0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn, input logic rem);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (sgn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return rem ? r : q;
    endfunction

    // Issue one request, scramble inputs while busy, check result and latency.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sgn, input logic rem,
                          input logic [31:0] exp_res, input int exp_lat);
        exp_t        e;
        exp_t        got_e;
        int          lat;
        bit          seen;
        logic [31:0] dmag;
        dmag = (sgn && b[31]) ? -b : b;
        @(negedge clk);
        div_op1_i    = a;
        div_op2_i    = b;
        div_signed_i = sgn;
        div_rem_i    = rem;
        div_req_i    = 1'b1;
        e.res = exp_res;
        e.lat = exp_lat;
        sb.push_back(e);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) chk({tag, " busy"}, {31'd0, div_busy_o}, 32'd1);
            if (lat == 2 && exp_lat == 34) begin
                chk({tag, " calc_op2"}, div2adder_op2_o, dmag);
                chk({tag, " calc_cmd"}, {31'd0, div2adder_cmd_o}, 32'd0);
            end
            if (div_rdy_o) begin
                seen      = 1'b1;
                div_req_i = 1'b0;
                if (sb.size() > 0) begin
                    got_e = sb.pop_front();
                    chk({tag, " res"}, div_res_o, got_e.res);
                    chk({tag, " lat"}, 32'(lat), 32'(got_e.lat));
                end
                chk({tag, " done_op1"}, div2adder_op1_o, 32'd0);
            end else begin
                div_op1_i    = $urandom;
                div_op2_i    = $urandom;
                div_signed_i = 1'($urandom);
                div_rem_i    = 1'($urandom);
                div_req_i    = 1'($urandom);
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $error("FAIL %s timeout: observed=no_rdy expected=rdy", tag);
            div_req_i = 1'b0;
            if (sb.size() > 0) void'(sb.pop_front());
        end
        @(posedge clk);
        #1;
        chk({tag, " rdy_drop"}, {31'd0, div_rdy_o}, 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic        r;
        int          rdy_cnt;
        rst          = 1'b1;
        div_req_i    = 1'b0;
        div_op1_i    = 32'd0;
        div_op2_i    = 32'd0;
        div_signed_i = 1'b0;
        div_rem_i    = 1'b0;
`ifdef SCR1_DIV_KILL_EN
        div_kill_i   = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst busy", {31'd0, div_busy_o}, 32'd0);
        chk("rst rdy", {31'd0, div_rdy_o}, 32'd0);
        chk("rst res", div_res_o, 32'd0);
        chk("rst op1", div2adder_op1_o, 32'd0);
        chk("rst op2", div2adder_op2_o, 32'd0);
        chk("rst cmd", {31'd0, div2adder_cmd_o}, 32'd0);
        rst = 1'b0;

        run_op("divu_100_7_q", 32'd100, 32'd7, 1'b0, 1'b0, 32'd14, 34);
        run_op("divu_100_7_r", 32'd100, 32'd7, 1'b0, 1'b1, 32'd2, 34);
        run_op("div_m7_2_q", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 32'hFFFF_FFFD, 34);
        run_op("div_m7_2_r", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 32'hFFFF_FFFF, 34);
        run_op("divu_max_1_q", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'hFFFF_FFFF, 34);
        run_op("divu_max_1_r", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, 32'd0, 34);
        run_op("divu_5_0_q", 32'd5, 32'd0, 1'b0, 1'b0, 32'hFFFF_FFFF, 1);
        run_op("divu_5_0_r", 32'd5, 32'd0, 1'b0, 1'b1, 32'd5, 1);
        run_op("div_m5_0_q", 32'hFFFF_FFFB, 32'd0, 1'b1, 1'b0, 32'hFFFF_FFFF, 1);
        run_op("div_m5_0_r", 32'hFFFF_FFFB, 32'd0, 1'b1, 1'b1, 32'hFFFF_FFFB, 1);
        run_op("div_ovf_q", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h8000_0000, 1);
        run_op("div_ovf_r", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'd0, 1);
        run_op("divu_min_max_r", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h8000_0000, 34);
        run_op("div_7_m3_q", 32'd7, 32'hFFFF_FFFD, 1'b1, 1'b0, 32'hFFFF_FFFE, 34);

        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = (i == 3) ? 32'd0 : ($urandom >> (i * 3));
            s = 1'(i);
            r = 1'(i >> 1);
            run_op("rand", a, b, s, r, ref_div(a, b, s, r), is_special(a, b, s) ? 1 : 34);
        end

        // Reset in the middle of CALC.
        @(negedge clk);
        div_op1_i    = 32'd1000;
        div_op2_i    = 32'd3;
        div_signed_i = 1'b0;
        div_rem_i    = 1'b0;
        div_req_i    = 1'b1;
        @(posedge clk);
        #1;
        div_req_i = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst busy", {31'd0, div_busy_o}, 32'd0);
        chk("midrst rdy", {31'd0, div_rdy_o}, 32'd0);
        chk("midrst res", div_res_o, 32'd0);
        chk("midrst op1", div2adder_op1_o, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_op("after_rst_9_3", 32'd9, 32'd3, 1'b0, 1'b0, 32'd3, 34);

`ifdef SCR1_DIV_KILL_EN
        @(negedge clk);
        div_op1_i  = 32'd1000;
        div_op2_i  = 32'd7;
        div_req_i  = 1'b1;
        @(posedge clk);
        #1;
        div_req_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        div_kill_i = 1'b1;
        @(posedge clk);
        #1;
        div_kill_i = 1'b0;
        chk("kill busy", {31'd0, div_busy_o}, 32'd0);
        rdy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (div_rdy_o) rdy_cnt++;
        end
        chk("kill no_rdy", 32'(rdy_cnt), 32'd0);
        @(negedge clk);
        div_req_i  = 1'b1;
        div_kill_i = 1'b1;
        @(posedge clk);
        #1;
        div_req_i  = 1'b0;
        div_kill_i = 1'b0;
        chk("kill_accept busy", {31'd0, div_busy_o}, 32'd0);
        run_op("after_kill_20_6", 32'd20, 32'd6, 1'b0, 1'b1, 32'd2, 34);
`else
        rdy_cnt = 0;
`endif

        chk("sb empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
